nic_mac_link_ready: RTL
=======================

Name: nic_mac_link_ready

Overview:
Returns MAC status to the NIC. It owns the MAC reset, sequences the MAC out of reset when the NIC enables it, and qualifies link-up over a stability window before raising MAC_READY. On disable it waits for transmit to drain before putting the MAC back into reset. It sits between the NIC control register block and the Ethernet MAC example-design top.

Parameters:
RESET_HOLD_CYCLES, 16, cycles mac_reset stays asserted after enable (>=1)
LINK_STABLE_CYCLES, 1024, consecutive synchronized link-up cycles required before READY (>=1)
DRAIN_TIMEOUT, 4096, maximum cycles spent waiting for tx_busy low in DRAIN (>=1)
CNT_W, 16, width of link_drop_count

Ports:
clk  in  1  system clock; every port is synchronous to it except mac_link_up
reset  in  1  synchronous, active-high block reset
ENABLE_MAC  in  1  NIC enable; level, already in the clk domain
mac_link_up  in  1  MAC link status; asynchronous, passed through a 2-flop synchronizer
tx_busy  in  1  MAC transmit path has a frame in flight
mac_reset  out  1  active-high reset to the MAC
MAC_READY  out  1  link qualified; NIC may queue traffic
MAC_STATUS  out  3  current state encoding
link_drop_count  out  CNT_W  count of link losses while READY; saturates at all-ones
drain_timeout  out  1  sticky flag: the last DRAIN ended on timeout

Behaviour:
- Reset (reset=1 at a clk edge): state OFF, mac_reset=1, MAC_READY=0, link_drop_count=0, drain_timeout=0, counters=0, synchronizer flops=0.
- All outputs are registered and reflect the current state. No combinational path runs from any input to any output.
- mac_link_up is seen as link_s 2 cycles after it changes.
- States and encodings: OFF=0, HOLD=1, WAIT_LINK=2, READY=3, DRAIN=4.
- OFF:
  - mac_reset=1.
  - ENABLE_MAC=1 -> HOLD; cnt cleared; drain_timeout cleared.
- HOLD:
  - mac_reset=1; cnt increments each cycle.
  - After exactly RESET_HOLD_CYCLES cycles in HOLD -> WAIT_LINK.
  - ENABLE_MAC=0 -> OFF immediately.
- WAIT_LINK:
  - mac_reset=0.
  - cnt counts consecutive link_s=1 cycles; link_s=0 clears cnt.
  - When cnt reaches LINK_STABLE_CYCLES -> READY; MAC_READY=1 from that edge.
  - ENABLE_MAC=0 -> OFF; mac_reset re-asserts on that edge.
- READY:
  - MAC_READY=1.
  - ENABLE_MAC=0 -> DRAIN (takes priority over a simultaneous link drop; no drop is counted).
  - Otherwise link_s=0 -> WAIT_LINK; cnt cleared; link_drop_count += 1, saturating.
- DRAIN:
  - MAC_READY=0, mac_reset=0; cnt counts cycles.
  - tx_busy=0 -> OFF.
  - Else when cnt reaches DRAIN_TIMEOUT -> OFF and drain_timeout=1.
  - ENABLE_MAC returning high during DRAIN is ignored. DRAIN always completes to OFF, and OFF re-enters HOLD on the next edge if ENABLE_MAC is still 1.
  - Link changes are ignored in DRAIN.
- cnt width: clog2 of the largest parameter, plus 1.
- MAC_READY is never 1 while mac_reset is 1.
- reset asserted in any state returns the block to OFF on the next edge.

Decomposition:
- Shared package nic_mac_pkg:
  - state encoding localparams (OFF..DRAIN);
  - MAC_STATUS width constant;
  - default timing constants.
- One sub-module: nic_mac_sync2, a generic 2-flop synchronizer with synchronous reset to 0, used for mac_link_up.

Test Plan (RESET_HOLD_CYCLES=4, LINK_STABLE_CYCLES=8, DRAIN_TIMEOUT=16):
1. Enable with link already up:
   - stimulus: reset, then ENABLE_MAC=1 at cycle 0, mac_link_up=1;
   - required: mac_reset=1 through cycle 4, 0 from cycle 5; MAC_READY=1 at cycle 13; MAC_STATUS goes 1->2->3.
2. Link glitch during qualification:
   - stimulus: in WAIT_LINK, link up for 5 cycles, down 1 cycle, then up;
   - required: READY only after 8 further consecutive synchronized-up cycles.
3. Link drop in READY:
   - stimulus: mac_link_up=0 for 3 cycles;
   - required: MAC_READY falls 3 cycles after the input change (2 synchronizer + 1); link_drop_count=1; state WAIT_LINK; re-READY 8 cycles after link_s returns.
4. Disable with tx draining:
   - stimulus: ENABLE_MAC=0 in READY with tx_busy=1 for 6 cycles;
   - required: MAC_READY=0 next cycle; mac_reset=1 one cycle after tx_busy falls; drain_timeout=0.
5. Drain timeout:
   - stimulus: tx_busy stuck at 1;
   - required: OFF after 16 DRAIN cycles; drain_timeout=1, held until the next entry to HOLD.
6. Simultaneous events and mid-operation reset:
   - stimulus: ENABLE_MAC=0 and link drop on the same cycle in READY;
   - required: DRAIN, link_drop_count unchanged.
   - stimulus: reset pulse mid-WAIT_LINK;
   - required: OFF, mac_reset=1, all counters 0.
   - stimulus: link_drop_count forced to saturation, then a further drop;
   - required: count holds at 0xFFFF.

Source files
------------

// File: rtl/nic_mac_pkg.sv
// Shared definitions for the NIC-side MAC bring-up block: state encoding,
// status width and default timing constants.
package nic_mac_pkg;

  localparam int STATUS_W = 3;

  // Default timing, in clk cycles.
  localparam int DEF_RESET_HOLD_CYCLES  = 16;
  localparam int DEF_LINK_STABLE_CYCLES = 1024;
  localparam int DEF_DRAIN_TIMEOUT      = 4096;
  localparam int DEF_CNT_W              = 16;

  // The encoding is visible to software through MAC_STATUS, so values are fixed.
  typedef enum logic [STATUS_W-1:0] {
    ST_OFF       = 3'd0,
    ST_HOLD      = 3'd1,
    ST_WAIT_LINK = 3'd2,
    ST_READY     = 3'd3,
    ST_DRAIN     = 3'd4
  } mac_state_e;

  // Largest of three values; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/nic_mac_sync2.sv
// Generic two-flop synchronizer for level signals crossing into the clk domain.
module nic_mac_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nic_mac_link_ready.sv
// MAC bring-up and link qualification. Owns the MAC reset, releases it after a
// hold period once the NIC enables the MAC, qualifies link-up over a stability
// window before raising MAC_READY, and drains transmit before re-asserting
// reset on disable. All outputs come straight from flops.
module nic_mac_link_ready
  import nic_mac_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int LINK_STABLE_CYCLES = DEF_LINK_STABLE_CYCLES,
  parameter int DRAIN_TIMEOUT      = DEF_DRAIN_TIMEOUT,
  parameter int CNT_W              = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ENABLE_MAC,
  input  logic                mac_link_up,
  input  logic                tx_busy,
  output logic                mac_reset,
  output logic                MAC_READY,
  output logic [STATUS_W-1:0] MAC_STATUS,
  output logic [CNT_W-1:0]    link_drop_count,
  output logic                drain_timeout
);

  // One counter serves hold, link-stability and drain timing; only one is live at a time.
  localparam int TIMER_W = $clog2(max3(RESET_HOLD_CYCLES, LINK_STABLE_CYCLES, DRAIN_TIMEOUT)) + 1;

  // Terminal counts: the transition happens on the edge that completes the Nth cycle.
  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(LINK_STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DRAIN_LAST  = TIMER_W'(DRAIN_TIMEOUT - 1);

  mac_state_e         state_q, state_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               dto_q, dto_d;
  logic               mac_reset_q, mac_reset_d;
  logic               ready_q, ready_d;
  logic               link_s;

  nic_mac_sync2 #(
    .WIDTH(1)
  ) u_link_sync (
    .clk  (clk),
    .reset(reset),
    .d    (mac_link_up),
    .q    (link_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      drop_q      <= '0;
      dto_q       <= 1'b0;
      mac_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      dto_q       <= dto_d;
      mac_reset_q <= mac_reset_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state, counter and status-flag logic.
  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    dto_d   = dto_q;

    case (state_q)
      ST_OFF: begin
        if (ENABLE_MAC) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          dto_d   = 1'b0;
        end
      end

      ST_HOLD: begin
        if (!ENABLE_MAC) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_LINK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TIMER_W'(1);
        end
      end

      ST_WAIT_LINK: begin
        if (!ENABLE_MAC) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (!link_s) begin
          // Any dropout restarts qualification from zero.
          cnt_d = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TIMER_W'(1);
        end
      end

      ST_READY: begin
        // Disable wins over a coincident link loss; that loss is not counted.
        if (!ENABLE_MAC) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else if (!link_s) begin
          state_d = ST_WAIT_LINK;
          cnt_d   = '0;
          if (drop_q != '1) begin
            drop_d = drop_q + CNT_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        // Enable and link are ignored here; DRAIN always finishes to OFF.
        if (!tx_busy) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = ST_OFF;
          cnt_d   = '0;
          dto_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TIMER_W'(1);
        end
      end

      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, so registered outputs track the state register.
  always_comb begin
    mac_reset_d = (state_d == ST_OFF) || (state_d == ST_HOLD);
    ready_d     = (state_d == ST_READY);
  end

  assign mac_reset       = mac_reset_q;
  assign MAC_READY       = ready_q;
  assign MAC_STATUS      = state_q;
  assign link_drop_count = drop_q;
  assign drain_timeout   = dto_q;

endmodule
